// File: rtl/route_sequencer.sv
// route_sequencer: steps through a programmed turn table, presenting each turn code per detected node.
// Handshakes node/node_r with the turn block; optional looping, turn timeout fault, abort.
module route_sequencer #(
    parameter int unsigned TURN_TIMEOUT = 150000000,
    parameter int unsigned TABLE_DEPTH  = 16
) (
    input  logic       i_clk_50,
    input  logic       i_rst_n,
    input  logic       i_prog_we,
    input  logic [3:0] i_prog_addr,
    input  logic [1:0] i_prog_dir,
    input  logic [4:0] i_route_len,
    input  logic       i_loop_en,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_node,
    input  logic       i_node_r,
    output logic [1:0] o_direction,
    output logic       o_busy,
    output logic [3:0] o_step_idx,
    output logic [3:0] o_lap_count,
    output logic       o_route_done,
    output logic       o_err_timeout
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_TURN, S_RELEASE, S_DONE, S_FAULT} state_t;
    localparam logic [27:0] TO_LIM = 28'(TURN_TIMEOUT - 1);
    state_t      r_state, w_next;
    logic [1:0]  r_table [TABLE_DEPTH];
    logic        r_node_d, r_loop, r_busy, r_done, r_err;
    logic [4:0]  r_len;
    logic [27:0] r_cnt;
    logic [1:0]  r_dir, w_dir_n;
    logic [3:0]  r_step, r_lap, w_step_n, w_lap_n;
    logic        w_rise, w_last, w_len_ok, w_timeout, w_start_arm, w_rel_arm;
    logic        w_busy_n, w_done_n, w_err_n;
    assign w_rise    = i_node & ~r_node_d;
    assign w_last    = {1'b0, r_step} == r_len - 5'd1;
    assign w_len_ok  = i_route_len != 5'd0 && i_route_len <= 5'd16;
    assign w_timeout = r_cnt >= TO_LIM;
    always_ff @(posedge i_clk_50) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = (i_start && w_len_ok) ? S_ARM : S_IDLE;
            S_ARM:     w_next = w_rise ? S_TURN : S_ARM;
            S_TURN:    w_next = i_node_r ? S_RELEASE : !i_node ? S_ARM : w_timeout ? S_FAULT : S_TURN;
            S_RELEASE: w_next = i_node ? S_RELEASE : (w_last && !r_loop) ? S_DONE : S_ARM;
            S_DONE:    w_next = S_IDLE;
            S_FAULT:   w_next = S_FAULT;
            default:   w_next = S_IDLE;
        endcase
        if (i_abort) w_next = S_IDLE;
    end
    always_comb begin
        w_start_arm = r_state == S_IDLE && w_next == S_ARM;
        w_rel_arm   = r_state == S_RELEASE && w_next == S_ARM;
        w_step_n    = (i_abort || w_start_arm) ? 4'd0 : w_rel_arm ? (w_last ? 4'd0 : r_step + 4'd1) : r_step;
        w_lap_n     = i_abort ? 4'd0 : (w_rel_arm && w_last) ? r_lap + 4'd1 : r_lap;
        w_err_n     = !i_abort && (r_err || w_next == S_FAULT);
        // Direction only reloads on ARM entry so the turn block sees a stable code mid-turn
        w_dir_n     = (w_next == S_IDLE || w_next == S_FAULT) ? 2'd3 :
                      (w_next == S_ARM && r_state != S_ARM) ? r_table[w_step_n] : r_dir;
        w_busy_n    = w_next == S_ARM || w_next == S_TURN || w_next == S_RELEASE;
        w_done_n    = w_next == S_DONE;
    end
    always_ff @(posedge i_clk_50) begin
        if (!i_rst_n) begin
            r_node_d <= 1'b0;
            r_cnt    <= '0;
            r_len    <= 5'd1;
            r_loop   <= 1'b0;
            r_dir    <= 2'd3;
            r_busy   <= 1'b0;
            r_step   <= 4'd0;
            r_lap    <= 4'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_node_d <= i_node;
            r_cnt    <= (r_state != S_TURN) ? '0 : (r_cnt != '1) ? r_cnt + 28'd1 : r_cnt;
            r_len    <= w_start_arm ? i_route_len : r_len;
            r_loop   <= w_start_arm ? i_loop_en : r_loop;
            r_dir    <= w_dir_n;
            r_busy   <= w_busy_n;
            r_step   <= w_step_n;
            r_lap    <= w_lap_n;
            r_done   <= w_done_n;
            r_err    <= w_err_n;
        end
    end
    always_ff @(posedge i_clk_50) begin
        if (!i_rst_n) begin
            for (int i = 0; i < TABLE_DEPTH; i++) r_table[i] <= 2'd3;
        end else if (i_prog_we && r_state == S_IDLE) begin
            r_table[i_prog_addr] <= i_prog_dir;
        end
    end
    assign o_direction   = r_dir;
    assign o_busy        = r_busy;
    assign o_step_idx    = r_step;
    assign o_lap_count   = r_lap;
    assign o_route_done  = r_done;
    assign o_err_timeout = r_err;
endmodule

// File: tb/tb_route_sequencer.sv
// tb_route_sequencer: directed vector table plus hand sequences for timeout, abort and reset.
module tb_route_sequencer;
    localparam int TO = 20;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       we = 1'b0, loop_en = 1'b0, start = 1'b0, abort = 1'b0, node = 1'b0, node_r = 1'b0;
    logic [3:0] addr = '0;
    logic [1:0] pdir = '0;
    logic [4:0] len = '0;
    logic [1:0] dir;
    logic       busy, done, err;
    logic [3:0] step, lap;
    int         n_vec = 0, n_bad = 0;
    typedef struct {
        int we, a, d, len, lp, st, ab, nd, nr;
        int e_dir, e_busy, e_step, e_lap, e_done, e_err;
    } vec_t;
    vec_t vq[$];
    route_sequencer #(.TURN_TIMEOUT(TO), .TABLE_DEPTH(16)) dut (
        .i_clk_50(clk), .i_rst_n(rst_n), .i_prog_we(we), .i_prog_addr(addr), .i_prog_dir(pdir),
        .i_route_len(len), .i_loop_en(loop_en), .i_start(start), .i_abort(abort),
        .i_node(node), .i_node_r(node_r), .o_direction(dir), .o_busy(busy), .o_step_idx(step),
        .o_lap_count(lap), .o_route_done(done), .o_err_timeout(err)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask
    task automatic chk_all(input string name, input int ed, input int eb, input int es, input int el, input int edn, input int ee);
        n_vec++;
        if (dir != 2'(ed) || busy != 1'(eb) || step != 4'(es) || lap != 4'(el) || done != 1'(edn) || err != 1'(ee)) begin
            n_bad++;
            $display("FAIL %s: got dir=%0d busy=%0d step=%0d lap=%0d done=%0d err=%0d, expected dir=%0d busy=%0d step=%0d lap=%0d done=%0d err=%0d",
                     name, dir, busy, step, lap, done, err, ed, eb, es, el, edn, ee);
        end
    endtask
    task automatic add(input int w, input int a, input int d, input int l, input int lp, input int st, input int ab,
                       input int nd, input int nr, input int ed, input int eb, input int es, input int el, input int edn, input int ee);
        vq.push_back('{w, a, d, l, lp, st, ab, nd, nr, ed, eb, es, el, edn, ee});
    endtask
    task automatic drive(input int s, input int nd, input int nr, input int ab);
        start = 1'(s); node = 1'(nd); node_r = 1'(nr); abort = 1'(ab);
    endtask
    initial begin
        //   we a d len lp st ab nd nr | dir busy step lap done err
        add(1, 0, 2, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
        add(1, 2, 0, 0, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 1, 0, 0, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 1, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 1, 1,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 0, 0,  0, 1, 2, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 1, 0,  0, 1, 2, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 1, 1,  0, 1, 2, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 0, 0,  0, 0, 2, 0, 1, 0);
        add(0, 0, 0, 3, 0, 0, 0, 0, 0,  3, 0, 2, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 0, 0,  3, 0, 2, 0, 0, 0);
        // looping route of length 2
        add(0, 0, 0, 2, 1, 1, 0, 0, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 1, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 1, 1,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 1, 0,  1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 1, 1,  1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 0, 0,  2, 1, 0, 1, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 1, 0,  2, 1, 0, 1, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 1, 1,  2, 1, 0, 1, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 0, 0,  1, 1, 1, 1, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 1, 0,  1, 1, 1, 1, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 1, 1,  1, 1, 1, 1, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 0, 0,  2, 1, 0, 2, 0, 0);
        add(0, 0, 0, 2, 0, 0, 1, 0, 0,  3, 0, 0, 0, 0, 0);
        add(0, 0, 0, 2, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
        // node drops in TURN before node_r
        add(0, 0, 0, 3, 0, 1, 0, 0, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 1, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 1, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 1, 1,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 1, 0, 0,  3, 0, 0, 0, 0, 0);
        // node already high on ARM entry must not count
        add(0, 0, 0, 3, 0, 1, 0, 1, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 1, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 1, 1,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 1, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 1, 1,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 3, 0, 0, 1, 0, 0,  3, 0, 0, 0, 0, 0);
        // writes outside IDLE dropped; start length bounds
        add(0, 0, 0, 1, 0, 1, 0, 0, 0,  2, 1, 0, 0, 0, 0);
        add(1, 0, 3, 1, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, 1,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0,  2, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0,  3, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1, 0, 0,  3, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0,  3, 0, 0, 0, 0, 0);
        add(0, 0, 0,17, 0, 1, 0, 0, 0,  3, 0, 0, 0, 0, 0);
        add(0, 0, 0,16, 0, 1, 0, 0, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 0,16, 0, 0, 1, 0, 0,  3, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_all("reset", 3, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        foreach (vq[i]) begin
            we = 1'(vq[i].we); addr = 4'(vq[i].a); pdir = 2'(vq[i].d); len = 5'(vq[i].len); loop_en = 1'(vq[i].lp);
            drive(vq[i].st, vq[i].nd, vq[i].nr, vq[i].ab);
            tick();
            chk_all($sformatf("vec%0d", i), vq[i].e_dir, vq[i].e_busy, vq[i].e_step, vq[i].e_lap, vq[i].e_done, vq[i].e_err);
        end
        we = 1'b0; len = 5'd3; loop_en = 1'b0;
        // turn timeout into FAULT
        drive(1, 0, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        for (int k = 1; k < TO; k++) tick();
        chk("to_pre_err", int'(err), 0);
        chk("to_pre_busy", int'(busy), 1);
        tick();
        chk_all("to_fault", 3, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0); tick();
        chk_all("fault_start_ignored", 3, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1); tick();
        chk_all("fault_abort", 3, 0, 0, 0, 0, 0);
        // node_r wins over a coincident timeout
        drive(1, 0, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        for (int k = 1; k < TO; k++) tick();
        drive(0, 1, 1, 0); tick();
        chk_all("to_vs_node_r", 2, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0); tick();
        chk_all("to_vs_node_r_adv", 1, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 1); tick();
        // reset during TURN at step 2
        drive(1, 0, 0, 0); tick();
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, 0); tick();
            drive(0, 1, 1, 0); tick();
            drive(0, 0, 0, 0); tick();
        end
        drive(0, 1, 0, 0); tick();
        chk_all("turn_step2", 0, 1, 2, 0, 0, 0);
        rst_n = 1'b0; tick();
        chk_all("mid_reset", 3, 0, 0, 0, 0, 0);
        rst_n = 1'b1; drive(0, 0, 0, 0); tick();
        chk_all("post_reset_no_done", 3, 0, 0, 0, 0, 0);
        len = 5'd1; drive(1, 0, 0, 0); tick();
        chk_all("table_reset_reads_3", 3, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1); tick();
        chk_all("final_abort", 3, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
